// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the PC, issues word fetches, queues two results.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect traps and halts.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pcsel,
    input  logic [31:0] alu_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misalign
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        out_q, out_d;
    logic        kill_q, kill_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] q0_pc_q, q0_pc_d;
    logic [31:0] q0_ins_q, q0_ins_d;
    logic [31:0] q1_pc_q, q1_pc_d;
    logic [31:0] q1_ins_q, q1_ins_d;
    logic        halt;
    logic [31:0] tgt;
    logic        accept;
    logic        push;
    logic        pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign halt     = misalign_q;
    assign tgt      = alu_target;
    assign misalign = misalign_q;

    // Each redirect re-evaluates the sticky misalign trap
    always_comb begin
        misalign_d = misalign_q;
        if (pcsel) begin
            misalign_d = |alu_target[1:0];
        end
    end

    // Misalign trap register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign halt     = 1'b0;
    assign tgt      = alu_target & 32'hFFFF_FFFC;
    assign misalign = 1'b0;
`endif

    // Only one fetch in flight, and only when the queue has a free slot
    assign imem_req_valid = reset_n && !out_q
                         && (count_q != 2'd2) && !halt;
    assign imem_addr      = pc_q;
    assign if_valid       = (count_q != 2'd0);
    assign if_pc          = q0_pc_q;
    assign if_instr       = q0_ins_q;

    assign accept = imem_req_valid && imem_req_ready;
    assign push   = imem_rsp_valid && !kill_q;
    assign pop    = if_valid && if_ready;

    // Next-state: redirect flushes everything, otherwise fetch/push/pop
    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        out_d    = out_q;
        kill_d   = kill_q;
        count_d  = count_q;
        q0_pc_d  = q0_pc_q;
        q0_ins_d = q0_ins_q;
        q1_pc_d  = q1_pc_q;
        q1_ins_d = q1_ins_q;
        if (imem_rsp_valid) begin
            out_d = 1'b0;
        end
        if (accept) begin
            out_d    = 1'b1;
            req_pc_d = pc_q;
        end
        if (pcsel) begin
            pc_d    = tgt;
            count_d = 2'd0;
            kill_d  = out_d;
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rsp_valid && kill_q) begin
                kill_d = 1'b0;
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        q0_pc_d  = req_pc_q;
                        q0_ins_d = imem_rsp_data;
                    end else begin
                        q1_pc_d  = req_pc_q;
                        q1_ins_d = imem_rsp_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    q0_pc_d  = q1_pc_q;
                    q0_ins_d = q1_ins_q;
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        q0_pc_d  = req_pc_q;
                        q0_ins_d = imem_rsp_data;
                    end else begin
                        q0_pc_d  = q1_pc_q;
                        q0_ins_d = q1_ins_q;
                        q1_pc_d  = req_pc_q;
                        q1_ins_d = imem_rsp_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            req_pc_q <= 32'd0;
            out_q    <= 1'b0;
            kill_q   <= 1'b0;
            count_q  <= 2'd0;
            q0_pc_q  <= 32'd0;
            q0_ins_q <= 32'd0;
            q1_pc_q  <= 32'd0;
            q1_ins_q <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            out_q    <= out_d;
            kill_q   <= kill_d;
            count_q  <= count_d;
            q0_pc_q  <= q0_pc_d;
            q0_ins_q <= q0_ins_d;
            q1_pc_q  <= q1_pc_d;
            q1_ins_q <= q1_ins_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: random imem/decode/redirect traffic,
// queue-based reference model, plus directed literal checks.
module tb_fetch_pc_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clock;
    logic        reset_n;
    logic        pcsel;
    logic [31:0] alu_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign;

    fetch_pc_unit #(.RESET_PC(RPC)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pcsel          (pcsel),
        .alu_target     (alu_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .misalign       (misalign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h @%0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [31:0] ihash(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ (a * 32'd3);
    endfunction

    // ---------------- imem stub ----------------
    typedef struct { logic [31:0] a; int due; } pend_t;
    pend_t pq[$];
    int cyc = 0;
    bit rdy_rand = 0;
    int lat_min = 1;
    int lat_max = 1;

    always @(posedge clock) begin
        if (reset_n && imem_req_valid && imem_req_ready)
            pq.push_back('{imem_addr,
                           cyc + int'($urandom_range(lat_max, lat_min))});
    end

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            pq.delete();
            imem_rsp_valid = 1'b0;
            imem_req_ready = 1'b0;
        end else begin
            if (pq.size() > 0 && cyc >= pq[0].due) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ihash(pq[0].a);
                void'(pq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            imem_req_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
        end
    end

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc, m_req_pc;
    bit          m_out, m_kill, m_mis;
    logic [31:0] acc_log[$];
    logic [31:0] dlv_log[$];

    function automatic bit m_rv();
        return reset_n && !m_out && mq.size() < 2 && !m_mis;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        bit acc, nout;
        if (!reset_n) begin
            m_pc = RPC; m_req_pc = 32'd0;
            m_out = 0; m_kill = 0; m_mis = 0;
            mq.delete();
        end else begin
            if (imem_req_valid && imem_req_ready)
                acc_log.push_back(imem_addr);
            if (if_valid && if_ready && !pcsel) begin
                dlv_log.push_back(if_pc);
                chk("deliver_instr", if_instr, ihash(if_pc));
            end
            acc  = m_rv() && imem_req_ready;
            nout = acc ? 1'b1 : (imem_rsp_valid ? 1'b0 : m_out);
            if (pcsel) begin
                mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
                m_pc  = alu_target;
                m_mis = (alu_target % 4) != 0;
`else
                m_pc  = alu_target - (alu_target % 4);
`endif
                m_kill = nout;
            end else begin
                if (acc) begin
                    m_req_pc = m_pc;
                    m_pc     = m_pc + 32'd4;
                end
                if (mq.size() > 0 && if_ready) void'(mq.pop_front());
                if (imem_rsp_valid) begin
                    if (m_kill) m_kill = 0;
                    else mq.push_back('{m_req_pc, imem_rsp_data});
                end
            end
            m_out = nout;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (reset_n) begin
            chk("req_valid", 32'(imem_req_valid), 32'(m_rv()));
            if (m_rv()) chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", 32'(if_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("if_pc", if_pc, mq[0].pc);
                chk("if_instr", if_instr, mq[0].ins);
            end
            chk("misalign", 32'(misalign), 32'(m_mis));
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] at(input logic [31:0] q[$],
                                       input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic redirect(input logic [31:0] t,
                            output int am, output int dm);
        @(negedge clock);
        pcsel = 1'b1; alu_target = t;
        @(negedge clock);
        pcsel = 1'b0;
        am = acc_log.size();
        dm = dlv_log.size();
    endtask

    task automatic reset_check();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int am, dm, t0;
        logic [31:0] tg;
        reset_n = 1'b1; pcsel = 1'b0; alu_target = 32'd0;
        if_ready = 1'b1;
        #3 reset_n = 1'b0;
        #1 reset_check();
        cycles(3);
        #2 reset_n = 1'b1;
        #1 chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_addr, RPC);

        // straight-line fetch
        cycles(8);
        chk("seq_acc0", at(acc_log, 0), 32'h0);
        chk("seq_acc1", at(acc_log, 1), 32'h4);
        chk("seq_acc2", at(acc_log, 2), 32'h8);
        chk("seq_dlv0", at(dlv_log, 0), 32'h0);
        chk("seq_dlv1", at(dlv_log, 1), 32'h4);
        chk("seq_dlv2", at(dlv_log, 2), 32'h8);

        // decode stall fills queue
        if_ready = 1'b0;
        cycles(10);
        chk("full_req_valid", 32'(imem_req_valid), 32'd0);
        chk("full_if_valid", 32'(if_valid), 32'd1);
        dm = dlv_log.size();
        if_ready = 1'b1;
        cycles(6);
        chk("drain_order",
            at(dlv_log, dm + 1), at(dlv_log, dm) + 32'd4);
        chk("drain_cont",
            at(dlv_log, dm), at(dlv_log, dm - 1) + 32'd4);

        // redirect while a fetch is outstanding
        lat_min = 3; lat_max = 3;
        t0 = 0;
        while (!imem_req_valid && t0 < 20) begin
            @(negedge clock); t0++;
        end
        chk("wait_req", 32'(imem_req_valid), 32'd1);
        redirect(32'h100, am, dm);
        chk("flush_if_valid", 32'(if_valid), 32'd0);
        lat_min = 1; lat_max = 1;
        cycles(12);
        chk("redir_acc", at(acc_log, am), 32'h100);
        chk("redir_dlv", at(dlv_log, dm), 32'h100);

        // back-to-back redirects
        @(negedge clock);
        pcsel = 1'b1; alu_target = 32'h200;
        @(negedge clock);
        alu_target = 32'h300;
        @(negedge clock);
        pcsel = 1'b0;
        dm = dlv_log.size();
        cycles(10);
        chk("b2b_dlv0", at(dlv_log, dm), 32'h300);
        chk("b2b_dlv1", at(dlv_log, dm + 1), 32'h304);

        // PC wrap
        redirect(32'hFFFF_FFFC, am, dm);
        cycles(10);
        chk("wrap_acc0", at(acc_log, am), 32'hFFFF_FFFC);
        chk("wrap_acc1", at(acc_log, am + 1), 32'h0);
        chk("wrap_dlv0", at(dlv_log, dm), 32'hFFFF_FFFC);
        chk("wrap_dlv1", at(dlv_log, dm + 1), 32'h0);

        // misaligned redirect
        redirect(32'h102, am, dm);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_set", 32'(misalign), 32'd1);
        cycles(6);
        chk("mis_no_req", 32'(acc_log.size()), 32'(am));
        chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mis_sticky", 32'(misalign), 32'd1);
        redirect(32'h104, am, dm);
        chk("mis_clear", 32'(misalign), 32'd0);
        cycles(8);
        chk("mis_resume_acc", at(acc_log, am), 32'h104);
        chk("mis_resume_dlv", at(dlv_log, dm), 32'h104);
`else
        cycles(8);
        chk("nomis_acc", at(acc_log, am), 32'h100);
        chk("nomis_dlv", at(dlv_log, dm), 32'h100);
        chk("nomis_flag", 32'(misalign), 32'd0);
`endif

        // randomized traffic with a mid-run reset
        rdy_rand = 1; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                #1 reset_check();
                pcsel = 1'b0;
                cycles(3);
                #2 reset_n = 1'b1;
                #1 chk("rerst_req_valid", 32'(imem_req_valid), 32'd1);
                chk("rerst_req_addr", imem_addr, RPC);
            end else begin
                if_ready = ($urandom % 10) < 7;
                pcsel    = ($urandom % 100) < 8;
                if ($urandom % 8 == 0)
                    tg = 32'hFFFF_FFF0 + (($urandom % 4) << 2);
                else
                    tg = ($urandom % 32'h1_0000) & 32'hFFFF_FFFC;
                if ($urandom % 5 == 0) tg = tg + ($urandom % 4);
                alu_target = tg;
            end
        end
        pcsel = 1'b0;
        cycles(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
